dmem_fill_arbiter: RTL and testbench

Sits between the CPU data port and DataMemory, and shares the single memory port between two requesters. Requester one is the CPU: highest priority, single-cycle access. Requester two is a built-in block-fill engine that writes a constant pattern over an address range, for example to clear or fill the screen region (16384..24575). The block owns the only `mem_*` drive into DataMemory.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/fill_sequencer.sv | 109 ++++++++++
 rtl/dmem_fill_arbiter.sv | 79 +++++++
 tb/tb_dmem_fill_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and types for the DataMemory fill arbiter.
// Build option: FILL_STARVE_GUARD_EN enables the fill starve guard.
package dmem_pkg;

  localparam int unsigned SCREEN_BASE  = 16384;
  localparam int unsigned SCREEN_WORDS = 8192;
  localparam int unsigned KBD_ADR      = 24576;

  localparam int ADR_W_DEF  = 15;
  localparam int DATA_W_DEF = 16;

  typedef logic [ADR_W_DEF-1:0]  adr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  // Keyboard register and everything above it is not backed by RAM.
  function automatic logic is_mapped(input int unsigned adr);
    return adr < KBD_ADR;
  endfunction

endpackage

// File: rtl/fill_sequencer.sv
// Block-fill engine: FSM, address/length counters and stall counter.
// Build option: FILL_STARVE_GUARD_EN lets the stall counter force a fill slot.
//
// state | meaning
// IDLE  | waiting for fill_start, latches base/len/pattern
// FILL  | one word per cycle not taken by the CPU
// DONE  | single-cycle completion pulse, then back to IDLE
module fill_sequencer
  import dmem_pkg::*;
#(
  parameter int          ADR_W     = 15,
  parameter int          DATA_W    = 16,
  parameter int          LEN_W     = 14,
  parameter int unsigned STALL_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fill_start,
  input  logic [ADR_W-1:0]  fill_base,
  input  logic [LEN_W-1:0]  fill_len,
  input  logic [DATA_W-1:0] fill_pattern,
  input  logic              cpu_gnt,
  output logic              fill_want,
  output logic [ADR_W-1:0]  fill_adr,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_wr_ok,
  output logic              fill_force,
  output logic              fill_busy,
  output logic              fill_done
);

  localparam int STALL_W = $clog2(STALL_MAX + 1);

  fill_state_t       state_q, state_d;
  logic [ADR_W-1:0]  cur_adr_q, cur_adr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [DATA_W-1:0] pattern_q, pattern_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic              busy_q, done_q;
  logic              fill_step;

  assign fill_step = (state_q == FILL) && !cpu_gnt;

  always_comb begin
    state_d   = state_q;
    cur_adr_d = cur_adr_q;
    remain_d  = remain_q;
    pattern_d = pattern_q;
    stall_d   = stall_q;
    case (state_q)
      IDLE: begin
        if (fill_start) begin
          cur_adr_d = fill_base;
          remain_d  = fill_len;
          pattern_d = fill_pattern;
          stall_d   = '0;
          state_d   = (fill_len != '0) ? FILL : DONE;
        end
      end
      FILL: begin
        if (fill_step) begin
          cur_adr_d = cur_adr_q + 1'b1;
          remain_d  = remain_q - 1'b1;
          stall_d   = '0;
          if (remain_q == LEN_W'(1)) state_d = DONE;
        end else if (32'(stall_q) < STALL_MAX) begin
          stall_d = stall_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_adr_q <= '0;
      remain_q  <= '0;
      pattern_q <= '0;
      stall_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_adr_q <= cur_adr_d;
      remain_q  <= remain_d;
      pattern_q <= pattern_d;
      stall_q   <= stall_d;
      busy_q    <= (state_d == FILL);
      done_q    <= (state_d == DONE);
    end
  end

`ifdef FILL_STARVE_GUARD_EN
  // After STALL_MAX consecutive stalls the next FILL cycle belongs to the engine.
  assign fill_force = (state_q == FILL) && (32'(stall_q) >= STALL_MAX);
`else
  assign fill_force = 1'b0;
`endif

  assign fill_want  = (state_q == FILL);
  assign fill_adr   = cur_adr_q;
  assign fill_data  = pattern_q;
  assign fill_wr_ok = is_mapped(32'(cur_adr_q));
  assign fill_busy  = busy_q;
  assign fill_done  = done_q;

endmodule

// File: rtl/dmem_fill_arbiter.sv
// Shares the single DataMemory port between the CPU (priority) and the fill engine.
// Build option: FILL_STARVE_GUARD_EN bounds how long the CPU can stall a fill.
module dmem_fill_arbiter
  import dmem_pkg::*;
#(
  parameter int          ADR_W     = 15,
  parameter int          DATA_W    = 16,
  parameter int          LEN_W     = 14,
  parameter int unsigned STALL_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADR_W-1:0]  cpu_adr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_gnt,
  input  logic              fill_start,
  input  logic [ADR_W-1:0]  fill_base,
  input  logic [LEN_W-1:0]  fill_len,
  input  logic [DATA_W-1:0] fill_pattern,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              mem_load,
  output logic [ADR_W-1:0]  mem_adr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  logic              fill_want;
  logic              fill_wr_ok;
  logic              fill_force;
  logic [ADR_W-1:0]  fill_adr;
  logic [DATA_W-1:0] fill_data;

  fill_sequencer #(
    .ADR_W     (ADR_W),
    .DATA_W    (DATA_W),
    .LEN_W     (LEN_W),
    .STALL_MAX (STALL_MAX)
  ) u_seq (
    .clk          (clk),
    .reset        (reset),
    .fill_start   (fill_start),
    .fill_base    (fill_base),
    .fill_len     (fill_len),
    .fill_pattern (fill_pattern),
    .cpu_gnt      (cpu_gnt),
    .fill_want    (fill_want),
    .fill_adr     (fill_adr),
    .fill_data    (fill_data),
    .fill_wr_ok   (fill_wr_ok),
    .fill_force   (fill_force),
    .fill_busy    (fill_busy),
    .fill_done    (fill_done)
  );

  assign cpu_gnt  = cpu_req && !fill_force;
  assign cpu_dout = mem_dout;

  // Idle port parks on the fill address with zero data.
  always_comb begin
    mem_load = 1'b0;
    mem_adr  = fill_adr;
    mem_din  = '0;
    if (cpu_gnt) begin
      mem_load = cpu_we;
      mem_adr  = cpu_adr;
      mem_din  = cpu_din;
    end else if (fill_want) begin
      mem_load = fill_wr_ok;
      mem_adr  = fill_adr;
      mem_din  = fill_data;
    end
    if (reset) mem_load = 1'b0;
  end

endmodule

// File: tb/tb_dmem_fill_arbiter.sv
// Self-checking bench for dmem_fill_arbiter: vector table, directed fill
// sequences and a randomized run against a behavioural memory/fill model.
module tb_dmem_fill_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [14:0] cpu_adr;
  logic [15:0] cpu_din, cpu_dout;
  logic        cpu_gnt;
  logic        fill_start;
  logic [14:0] fill_base;
  logic [13:0] fill_len;
  logic [15:0] fill_pattern;
  logic        fill_busy, fill_done;
  logic        mem_load;
  logic [14:0] mem_adr;
  logic [15:0] mem_din, mem_dout;

  always #5 clk = ~clk;

  dmem_fill_arbiter #(
    .ADR_W(15), .DATA_W(16), .LEN_W(14), .STALL_MAX(8)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_gnt(cpu_gnt),
    .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
    .fill_pattern(fill_pattern), .fill_busy(fill_busy), .fill_done(fill_done),
    .mem_load(mem_load), .mem_adr(mem_adr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // DataMemory stand-in: RAM below the keyboard address, writes above ignored.
  logic [15:0] dmem [0:32767];
  logic        mem_clr;
  assign mem_dout = dmem[mem_adr];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int a = 0; a < 32768; a++) dmem[a] <= 16'h0;
    end else if (mem_load && int'(mem_adr) < 24576) begin
      dmem[mem_adr] <= mem_din;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_in();
    cpu_req = 0; cpu_we = 0; cpu_adr = '0; cpu_din = '0;
    fill_start = 0; fill_base = '0; fill_len = '0; fill_pattern = '0;
  endtask

  task automatic do_reset();
    reset = 1; idle_in();
    cyc(); cyc();
    reset = 0;
  endtask

  typedef struct {
    logic        req;
    logic        we;
    logic [14:0] adr;
    logic [15:0] din;
    logic        exp_gnt;
    logic        exp_load;
    logic        chk_dout;
    logic [15:0] exp_dout;
  } vec_t;
  vec_t vecs[8];

  // randomized-phase model state
  logic [15:0] expm    [0:32767];
  bit          touched [0:32767];
  int          m_state;     // 0 idle, 1 filling, 2 done pulse due
  int          m_rem;
  logic [14:0] m_adr;
  logic [15:0] m_pat;
  int e_gnt, e_rd, e_mux, e_busy, e_done, e_fw, e_mem, n_fills;

  int werr, done_at, ngnt, nload, cnt;
  bit ok;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 15'd100,   16'h1234, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 15'd100,   16'h0000, 1'b1, 1'b0, 1'b1, 16'h1234};
    vecs[2] = '{1'b1, 1'b1, 15'd24576, 16'hBEEF, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 15'd24576, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};
    vecs[4] = '{1'b0, 1'b1, 15'd101,   16'hDEAD, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[5] = '{1'b1, 1'b0, 15'd101,   16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};
    vecs[6] = '{1'b1, 1'b1, 15'd24575, 16'h5A5A, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[7] = '{1'b1, 1'b0, 15'd24575, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h5A5A};

    // reset: CPU write attempted during reset must not reach memory
    reset = 1; mem_clr = 1; idle_in();
    cyc();
    mem_clr = 0;
    cpu_req = 1; cpu_we = 1; cpu_adr = 15'd50; cpu_din = 16'h0005;
    settle();
    chk("rst_mem_load", mem_load, 0);
    chk("rst_busy", fill_busy, 0);
    chk("rst_done", fill_done, 0);
    cyc();
    reset = 0; idle_in();
    settle();
    chk("rst_no_write", dmem[50], 16'h0);
    cyc();

    // CPU-only vector table
    for (int i = 0; i < 8; i++) begin
      cpu_req = vecs[i].req; cpu_we = vecs[i].we;
      cpu_adr = vecs[i].adr; cpu_din = vecs[i].din;
      settle();
      chk($sformatf("vec%0d_gnt", i), cpu_gnt, vecs[i].exp_gnt);
      chk($sformatf("vec%0d_load", i), mem_load, vecs[i].exp_load);
      if (vecs[i].chk_dout) chk($sformatf("vec%0d_dout", i), cpu_dout, vecs[i].exp_dout);
      cyc();
    end
    idle_in();

    // len=0: done the next cycle, never a write
    fill_start = 1; fill_base = 15'd300; fill_len = '0; fill_pattern = 16'hFFFF;
    settle();
    chk("len0_busy_start", fill_busy, 0);
    cyc(); idle_in(); settle();
    chk("len0_done", fill_done, 1);
    chk("len0_busy", fill_busy, 0);
    chk("len0_load", mem_load, 0);
    cyc(); settle();
    chk("len0_done_clear", fill_done, 0);
    chk("len0_no_write", dmem[300], 16'h0);
    cyc();

    // full screen fill with no CPU traffic
    fill_start = 1; fill_base = 15'd16384; fill_len = 14'd8192; fill_pattern = 16'h7777;
    cyc(); idle_in();
    werr = 0;
    for (int i = 0; i < 8192; i++) begin
      settle();
      if (!(mem_load && int'(mem_adr) == 16384 + i && mem_din == 16'h7777 && fill_busy && !fill_done))
        werr++;
      cyc();
    end
    settle();
    chk("screen_write_errs", werr, 0);
    chk("screen_done", fill_done, 1);
    chk("screen_busy_low", fill_busy, 0);
    chk("screen_load_low", mem_load, 0);
    chk("screen_first", dmem[16384], 16'h7777);
    chk("screen_last", dmem[24575], 16'h7777);
    cyc();

    // fill 200..209 with three CPU writes mid-fill
    fill_start = 1; fill_base = 15'd200; fill_len = 14'd10; fill_pattern = 16'hC3C3;
    cyc(); idle_in();
    done_at = 0; ngnt = 0;
    for (int c = 1; c <= 40; c++) begin
      cpu_req = (c >= 4 && c <= 6);
      cpu_we  = cpu_req;
      cpu_adr = 15'(300 + c - 4);
      cpu_din = 16'(16'h0011 * (c - 3));
      settle();
      if (cpu_req && cpu_gnt) ngnt++;
      if (fill_done) begin done_at = c; break; end
      cyc();
    end
    chk("cpumix_gnt_count", ngnt, 3);
    chk("cpumix_done_cycle", done_at, 14);
    cyc(); idle_in(); settle();
    cnt = 0;
    for (int a = 200; a < 210; a++) if (dmem[a] == 16'hC3C3) cnt++;
    chk("cpumix_fill_words", cnt, 10);
    chk("cpumix_no_over", dmem[210], 16'h0);
    chk("cpumix_cpu300", dmem[300], 16'h0011);
    chk("cpumix_cpu302", dmem[302], 16'h0033);
    cyc();

    // fill across the keyboard boundary: only 24574/24575 may be written
    fill_start = 1; fill_base = 15'd24574; fill_len = 14'd4; fill_pattern = 16'h9999;
    cyc(); idle_in();
    done_at = 0; nload = 0;
    for (int c = 1; c <= 20; c++) begin
      settle();
      if (mem_load) nload++;
      if (fill_done) begin done_at = c; break; end
      cyc();
    end
    chk("kbd_loads", nload, 2);
    chk("kbd_done_cycle", done_at, 5);
    chk("kbd_24575", dmem[24575], 16'h9999);
    cyc();

    // reset during word 6 of a 20-word fill
    fill_start = 1; fill_base = 15'd1000; fill_len = 14'd20; fill_pattern = 16'h0E0E;
    cyc(); idle_in();
    for (int c = 1; c <= 5; c++) begin settle(); cyc(); end
    reset = 1;
    settle();
    chk("rstmid_load", mem_load, 0);
    cyc();
    reset = 0;
    settle();
    chk("rstmid_busy", fill_busy, 0);
    chk("rstmid_done", fill_done, 0);
    chk("rstmid_load_after", mem_load, 0);
    cnt = 0;
    for (int a = 1000; a < 1020; a++) if (dmem[a] == 16'h0E0E) cnt++;
    chk("rstmid_words", cnt, 5);
    cyc();

    // continuous CPU requests during a 5-word fill
    fill_start = 1; fill_base = 15'd2000; fill_len = 14'd5; fill_pattern = 16'h0F0F;
    cyc(); idle_in();
    werr = 0; done_at = 0;
`ifdef FILL_STARVE_GUARD_EN
    for (int c = 1; c <= 60; c++) begin
      cpu_req = 1; cpu_we = 0; cpu_adr = 15'd50;
      settle();
      if (fill_done) begin done_at = c; break; end
      if (cpu_gnt !== ((c % 9) != 0)) werr++;
      if ((c % 9) == 0 && !(mem_load && mem_din == 16'h0F0F)) werr++;
      cyc();
    end
    chk("starve_pattern_errs", werr, 0);
    chk("starve_done_cycle", done_at, 46);
`else
    for (int c = 1; c <= 100; c++) begin
      cpu_req = (c <= 60); cpu_we = 0; cpu_adr = 15'd50;
      settle();
      if (fill_done) begin done_at = c; break; end
      if (c <= 60 && (!cpu_gnt || !fill_busy)) werr++;
      cyc();
    end
    chk("prio_stall_errs", werr, 0);
    chk("prio_done_cycle", done_at, 66);
`endif
    cyc(); idle_in(); settle();
    cnt = 0;
    for (int a = 2000; a < 2005; a++) if (dmem[a] == 16'h0F0F) cnt++;
    chk("contreq_words", cnt, 5);
    cyc();

    // randomized traffic against the behavioural model
    do_reset();
    for (int a = 0; a < 32768; a++) begin touched[a] = 0; expm[a] = 16'h0; end
    m_state = 0; m_rem = 0; m_adr = '0; m_pat = '0;
    e_gnt = 0; e_rd = 0; e_mux = 0; e_busy = 0; e_done = 0; e_fw = 0; e_mem = 0; n_fills = 0;
    for (int cy = 0; cy < 4000 || (cy < 4300 && m_state != 0); cy++) begin
      cpu_req = ($urandom_range(0, 2) == 0);
      cpu_we  = $urandom_range(0, 1) == 1;
      cpu_adr = 15'($urandom_range(1024, 2047));
      cpu_din = 16'($urandom);
      if (cy >= 4000) fill_start = 0;
      else fill_start = (m_state == 0) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 7) == 0);
      fill_base    = 15'($urandom_range(2048, 32767));
      fill_len     = 14'($urandom_range(0, 40));
      fill_pattern = 16'($urandom);
      settle();
`ifdef FILL_STARVE_GUARD_EN
      if (cpu_gnt && !cpu_req) e_gnt++;
`else
      if (cpu_gnt !== cpu_req) e_gnt++;
`endif
      if (cpu_gnt && !cpu_we && touched[cpu_adr] && cpu_dout !== expm[cpu_adr]) e_rd++;
      if (cpu_gnt && (mem_load !== cpu_we || mem_adr !== cpu_adr || mem_din !== cpu_din)) e_mux++;
      if (!cpu_gnt && m_state != 1 && mem_load !== 1'b0) e_mux++;
      if (fill_busy !== (m_state == 1)) e_busy++;
      if (fill_done !== (m_state == 2)) e_done++;
      if (m_state == 1 && !cpu_gnt) begin
        ok = int'(m_adr) < 24576;
        if (mem_load !== ok || mem_adr !== m_adr || (ok && mem_din !== m_pat)) e_fw++;
      end
      if (cpu_gnt && cpu_we) begin expm[cpu_adr] = cpu_din; touched[cpu_adr] = 1; end
      case (m_state)
        0: if (fill_start) begin
             m_adr = fill_base; m_rem = int'(fill_len); m_pat = fill_pattern;
             m_state = (fill_len == 0) ? 2 : 1;
             n_fills++;
           end
        1: if (!cpu_gnt) begin
             if (int'(m_adr) < 24576) begin expm[m_adr] = m_pat; touched[m_adr] = 1; end
             m_adr = m_adr + 15'd1;
             m_rem--;
             if (m_rem == 0) m_state = 2;
           end
        default: m_state = 0;
      endcase
      cyc();
    end
    idle_in();
    chk("rnd_drained", m_state, 0);
    for (int a = 0; a < 32768; a++) if (touched[a] && dmem[a] !== expm[a]) e_mem++;
    chk("rnd_gnt_errs", e_gnt, 0);
    chk("rnd_read_errs", e_rd, 0);
    chk("rnd_mux_errs", e_mux, 0);
    chk("rnd_busy_errs", e_busy, 0);
    chk("rnd_done_errs", e_done, 0);
    chk("rnd_fillwr_errs", e_fw, 0);
    chk("rnd_mem_errs", e_mem, 0);
    chk("rnd_enough_fills", n_fills >= 20, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
